// File: rtl/result_pkg.sv
// result_pkg: shared widths and types for the result collector.
package result_pkg;
    localparam int RES_WIDTH = 4;
    localparam int ACC_EXTRA = 4;
    typedef logic [RES_WIDTH-1:0] res_t;
endpackage

// File: rtl/result_fifo.sv
// result_fifo: first-word-fall-through FIFO with registered occupancy and flags.
module result_fifo #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       clr_i,
    input  logic                       valid_i,
    input  logic [WIDTH-1:0]           data_i,
    input  logic                       ready_i,
    output logic                       push_o,
    output logic                       pop_o,
    output logic [WIDTH-1:0]           data_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic                       full_o,
    output logic                       empty_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0]    count_q, count_d;
    assign empty_o = count_q == '0;
    assign full_o  = count_q == CW'(DEPTH);
    assign count_o = count_q;
    assign pop_o   = !empty_o && ready_i;
    // a pop frees the slot this cycle, so a full FIFO can still accept
    assign push_o  = valid_i && (!full_o || pop_o);
    assign data_o  = empty_o ? '0 : mem_q[rd_q];
    always_comb begin
        wr_d    = clr_i ? '0 : push_o ? wr_q + AW'(1) : wr_q;
        rd_d    = clr_i ? '0 : pop_o ? rd_q + AW'(1) : rd_q;
        count_d = clr_i ? '0 : (push_o && !pop_o) ? count_q + CW'(1) :
                  (pop_o && !push_o) ? count_q - CW'(1) : count_q;
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
        end
    end
    always_ff @(posedge clk) begin
        if (push_o && !clr_i) mem_q[wr_q] <= data_i;
    end
endmodule

// File: rtl/result_collector.sv
// result_collector: buffers arithmetic results for a valid/ready consumer, with sticky drop flag.
// Define RESULT_COLLECTOR_ACC_EN to build the running accumulator behind acc_sum.
module result_collector
    import result_pkg::*;
#(
    parameter int WIDTH = RES_WIDTH,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       clr,
    input  logic                       in_valid,
    input  logic [WIDTH-1:0]           in_res,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_data,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty,
    output logic                       drop,
    output logic [WIDTH+ACC_EXTRA-1:0] acc_sum
);
    logic push, pop, drop_q, drop_d;
    result_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .clr_i   (clr),
        .valid_i (in_valid),
        .data_i  (in_res),
        .ready_i (out_ready),
        .push_o  (push),
        .pop_o   (pop),
        .data_o  (out_data),
        .count_o (count),
        .full_o  (full),
        .empty_o (empty)
    );
    assign out_valid = !empty;
    // upstream has no backpressure: any strobe not pushed is a lost result
    assign drop_d = clr ? 1'b0 : drop_q | (in_valid && !push);
    assign drop   = drop_q;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) drop_q <= 1'b0;
        else drop_q <= drop_d;
    end
`ifdef RESULT_COLLECTOR_ACC_EN
    logic [WIDTH+ACC_EXTRA-1:0] acc_q, acc_d;
    assign acc_d   = clr ? '0 : push ? acc_q + (WIDTH+ACC_EXTRA)'(in_res) : acc_q;
    assign acc_sum = acc_q;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) acc_q <= '0;
        else acc_q <= acc_d;
    end
`else
    assign acc_sum = '0;
`endif
endmodule
